// File: rtl/reg_bus_master_if.sv
// Register-bus master signal bundle: serial byte stream in/out, register bus, status.
`timescale 1ns/1ps
`default_nettype none

interface reg_bus_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;
  logic                  o_wr;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  o_busy;
  logic                  o_timeout;
  logic                  o_overrun;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_rdata,
    output o_tx_data, o_tx_valid, o_wr, o_addr, o_wdata, o_busy, o_timeout, o_overrun
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_rdata,
    input  o_tx_data, o_tx_valid, o_wr, o_addr, o_wdata, o_busy, o_timeout, o_overrun
  );
endinterface

`default_nettype wire

// File: rtl/reg_bus_master.sv
// reg_bus_master: decodes framed write/read byte commands into register-bus cycles
// and returns one response byte per frame.
`timescale 1ns/1ps
`default_nettype none

module reg_bus_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  reg_bus_master_if.master  bus
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam int         TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_BUS_WR   = 3'd3,
    S_BUS_RD   = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_SEND     = 3'd6
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  is_write;
  logic [ADDR_WIDTH-1:0] addr_buf;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0]            tx_data_q;
  logic [TW-1:0]         timer;
  logic                  overrun_q;
  logic                  in_frame;
  logic                  expire;

  assign in_frame = (state == S_GET_ADDR) || (state == S_GET_DATA);

  // Timer holds the number of silent cycles minus one since the last accepted byte;
  // expiry fires on the (TIMEOUT_CYCLES-1)th silent cycle, and a byte always wins.
  always_comb begin
    state_nxt = state;
    expire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == CMD_WRITE || bus.i_rx_data == CMD_READ) state_nxt = S_GET_ADDR;
          else                                                           state_nxt = S_SEND;
        end
      end
      S_GET_ADDR: begin
        if (bus.i_rx_valid)          state_nxt = is_write ? S_GET_DATA : S_BUS_RD;
        else if (timer == TIMER_LAST) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (bus.i_rx_valid)          state_nxt = S_BUS_WR;
        else if (timer == TIMER_LAST) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_BUS_WR:  state_nxt = S_SEND;
      S_BUS_RD:  state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = S_SEND;
      S_SEND: begin
        if (bus.i_tx_ready) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      is_write  <= 1'b0;
      addr_buf  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      timer     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state <= state_nxt;

      if (bus.i_rx_valid || !in_frame) timer <= '0;
      else                             timer <= timer + TW'(1);

      case (state)
        S_IDLE: begin
          if (bus.i_rx_valid) begin
            is_write <= (bus.i_rx_data == CMD_WRITE);
            if (bus.i_rx_data != CMD_WRITE && bus.i_rx_data != CMD_READ) tx_data_q <= RSP_ERR;
          end
        end
        // Bus address only moves when a bus cycle starts; writes park it in addr_buf.
        S_GET_ADDR: begin
          if (bus.i_rx_valid) begin
            if (is_write) addr_buf <= bus.i_rx_data[ADDR_WIDTH-1:0];
            else          addr_q   <= bus.i_rx_data[ADDR_WIDTH-1:0];
          end
        end
        S_GET_DATA: begin
          if (bus.i_rx_valid) begin
            addr_q  <= addr_buf;
            wdata_q <= bus.i_rx_data;
          end
        end
        S_BUS_WR:  tx_data_q <= RSP_ACK;
        S_RD_WAIT: tx_data_q <= bus.i_rdata;
        default: ;
      endcase

      if (bus.i_rx_valid && (state == S_BUS_WR || state == S_BUS_RD ||
                             state == S_RD_WAIT || state == S_SEND))
        overrun_q <= 1'b1;
    end
  end

  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_valid = (state == S_SEND);
  assign bus.o_wr       = (state == S_BUS_WR);
  assign bus.o_addr     = addr_q;
  assign bus.o_wdata    = wdata_q;
  assign bus.o_busy     = (state != S_IDLE);
  assign bus.o_timeout  = expire && !i_rst;
  assign bus.o_overrun  = overrun_q;

endmodule

`default_nettype wire
